// File: rtl/glc_cfg_pkg.sv
// rtl/glc_cfg_pkg.sv - shared types and constants for the glc config-bus arbiter
package glc_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } cfg_arb_state_e;

    localparam int REQ_JTAG    = 0;
    localparam int REQ_AXI     = 1;
    localparam int CFG_NUM_REQ = 2;

endpackage

// File: rtl/glc_rr_arb.sv
// rtl/glc_rr_arb.sv - combinational round-robin picker, searching cyclically from ptr+1
module glc_rr_arb
    import glc_cfg_pkg::*;
#(
    parameter int NUM_REQ = CFG_NUM_REQ,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/glc_cfg_arbiter.sv
// rtl/glc_cfg_arbiter.sv - round-robin sharing of the CGRA config bus between JTAG and AXI-lite
module glc_cfg_arbiter
    import glc_cfg_pkg::*;
#(
    parameter int NUM_REQ    = CFG_NUM_REQ,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         config_addr_out,
    output logic [DATA_W-1:0]         config_data_out,
    output logic                      config_write,
    output logic                      config_read,
    input  logic [DATA_W-1:0]         config_data_in,
    output logic                      busy
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    cfg_arb_state_e   state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  cur_id;
    logic [ID_W-1:0]  win_id;
    logic [NUM_REQ-1:0] grant;
    logic [3:0]       cnt;

    glc_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    ((state == IDLE) && rst_n),
        .grant (grant),
        .id    (win_id)
    );

    assign req_ready = grant;

    // The config_* registers double as the latched request: they only carry
    // the transaction during ISSUE and are zeroed everywhere else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= ID_W'(NUM_REQ - 1);
            cur_id          <= '0;
            cnt             <= '0;
            config_addr_out <= '0;
            config_data_out <= '0;
            config_write    <= 1'b0;
            config_read     <= 1'b0;
            rsp_valid       <= '0;
            rsp_rdata       <= '0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        cur_id          <= win_id;
                        ptr             <= win_id;
                        config_addr_out <= req_addr[int'(win_id)*ADDR_W +: ADDR_W];
                        config_write    <= req_write[win_id];
                        config_read     <= !req_write[win_id];
                        config_data_out <= req_write[win_id] ?
                                           req_wdata[int'(win_id)*DATA_W +: DATA_W] : '0;
                        busy            <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    config_addr_out <= '0;
                    config_data_out <= '0;
                    config_write    <= 1'b0;
                    config_read     <= 1'b0;
                    if (config_write) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt   <= 4'(RD_LATENCY - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_rdata <= config_data_in;
                        rsp_valid <= NUM_REQ'(1) << cur_id;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready[cur_id]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_glc_cfg_arbiter.sv
// tb/tb_glc_cfg_arbiter.sv - scoreboard bench for glc_cfg_arbiter
module tb_glc_cfg_arbiter;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_write = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b11;
    logic [31:0] rsp_rdata;
    logic [31:0] config_addr_out;
    logic [31:0] config_data_out;
    logic        config_write;
    logic        config_read;
    logic [31:0] config_data_in = '0;
    logic        busy;

    glc_cfg_arbiter #(
        .NUM_REQ    (2),
        .ADDR_W     (32),
        .DATA_W     (32),
        .RD_LATENCY (RD_LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .config_addr_out (config_addr_out),
        .config_data_out (config_data_out),
        .config_write    (config_write),
        .config_read     (config_read),
        .config_data_in  (config_data_in),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } cfg_t;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } rsp_t;

    cfg_t exp_cfg[$];
    rsp_t exp_rsp[$];
    cfg_t ce;
    rsp_t re;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h0000_0010) ? 32'h1234_5678 : {a[15:0], 16'hC0DE};
    endfunction

    function automatic logic [31:0] caddr(input int id);
        return 32'h0000_0A00 | 32'(id);
    endfunction

    function automatic logic [31:0] cdata(input int id);
        return 32'hC0FF_EE00 | 32'(id);
    endfunction

    // CGRA model: read data is valid only in cycle T+RD_LAT after the strobe.
    int          rd_cd = 0;
    logic [31:0] rd_val = '0;
    always @(negedge clk) begin
        config_data_in = 32'hBAD0_BAD0;
        if (rd_cd != 0) begin
            rd_cd--;
            if (rd_cd == 0) config_data_in = rd_val;
        end
        if (config_read) begin
            rd_cd  = RD_LAT;
            rd_val = memf(config_addr_out);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (config_write || config_read) begin
                if (exp_cfg.size() == 0) begin
                    chk("cfg_unexpected", 1, 0);
                end else begin
                    ce = exp_cfg.pop_front();
                    chk("cfg_kind", {config_write, config_read}, {ce.wr, !ce.wr});
                    chk("cfg_addr", config_addr_out, ce.addr);
                    chk("cfg_data", config_data_out, ce.wr ? ce.data : 32'h0);
                end
            end
            if (|(rsp_valid & rsp_ready)) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    re = exp_rsp.pop_front();
                    chk("rsp_id", rsp_valid, re.id ? 2'b10 : 2'b01);
                    chk("rsp_rdata", rsp_rdata, re.data);
                end
            end
        end
    end

    task automatic push_cfg(input logic wr, input logic [31:0] a, input logic [31:0] d);
        cfg_t c;
        c.wr = wr; c.addr = a; c.data = d;
        exp_cfg.push_back(c);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_cfg.delete();
        exp_rsp.delete();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < 100, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_req(input int id, input logic wr, input logic [31:0] a, input logic [31:0] d);
        int   n;
        rsp_t r;
        push_cfg(wr, a, d);
        if (!wr) begin
            r.id = id[0]; r.data = memf(a);
            exp_rsp.push_back(r);
        end
        req_write[id] = wr;
        req_addr[id*32 +: 32] = a;
        req_wdata[id*32 +: 32] = d;
        req_valid[id] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("grant_timeout", n < 50, 1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic contend(input int ncyc, input int first);
        logic [1:0] e;
        for (int g = 0; g < (ncyc + 1) / 2; g++) begin
            push_cfg(1'b1, caddr(first ^ (g % 2)), cdata(first ^ (g % 2)));
        end
        req_write = 2'b11;
        req_addr  = {caddr(1), caddr(0)};
        req_wdata = {cdata(1), cdata(0)};
        req_valid = 2'b11;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c % 2 == 1) e = 2'b00;
            else e = ((first ^ ((c / 2) % 2)) == 1) ? 2'b10 : 2'b01;
            chk("rr_grant", req_ready, e);
            @(posedge clk); #1;
        end
        req_valid = '0;
        wait_idle();
    endtask

    task automatic random_mix(input int count);
        int          id;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        rsp_ready = 2'b11;
        for (int i = 0; i < count; i++) begin
            id = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            a  = $urandom;
            d  = $urandom;
            do_req(id, wr, a, d);
            wait_idle();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int n;

        reset_dut();
        @(negedge clk);
        chk("rst_ctrl", {busy, config_write, config_read, rsp_valid, req_ready}, 0);
        chk("rst_addr", config_addr_out, 0);
        chk("rst_data", config_data_out, 0);
        chk("rst_rdata", rsp_rdata, 0);
        @(posedge clk); #1;

        // single AXI write
        push_cfg(1'b1, 32'h0001_0020, 32'hDEAD_BEEF);
        req_write[1] = 1'b1;
        req_addr[63:32] = 32'h0001_0020;
        req_wdata[63:32] = 32'hDEAD_BEEF;
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk("t1_ready", req_ready, 2'b10);
        chk("t1_busy_pre", busy, 0);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("t1_write", config_write, 1);
        chk("t1_busy", busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_write_end", config_write, 0);
        chk("t1_busy_end", busy, 0);
        @(posedge clk); #1;

        // JTAG read with back-pressure; rsp_ready[1] must be ignored
        rsp_ready = 2'b10;
        do_req(0, 1'b0, 32'h0000_0010, 32'h0);
        @(negedge clk);
        chk("t2_read", config_read, 1);
        n = 0;
        while (!rsp_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t2_latency", n, RD_LAT + 1);
        chk("t2_rdata", rsp_rdata, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", rsp_valid, 2'b01);
            chk("t2_hold_rdata", rsp_rdata, 32'h1234_5678);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("t2_valid_hs", rsp_valid, 2'b01);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_valid_drop", rsp_valid, 2'b00);
        chk("t2_rdata_keep", rsp_rdata, 32'h1234_5678);
        chk("t2_busy_end", busy, 0);
        @(posedge clk); #1;

        // contention from reset: 0,1,0,1
        reset_dut();
        contend(7, 0);

        // pointer memory
        for (int i = 0; i < 3; i++) begin
            do_req(1, 1'b1, 32'h0000_0300 + 32'(i), 32'h0BAD_0000 + 32'(i));
            wait_idle();
        end
        contend(3, 0);

        // busy blocking of req 1 during a JTAG read
        rsp_ready = 2'b10;
        do_req(0, 1'b0, 32'h0000_0044, 32'h0);
        @(posedge clk); #1;
        push_cfg(1'b1, 32'h0002_0000, 32'h5555_AAAA);
        req_write[1] = 1'b1;
        req_addr[63:32] = 32'h0002_0000;
        req_wdata[63:32] = 32'h5555_AAAA;
        req_valid[1] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rsp_valid[0] && n < 20) begin
            chk("t5_block_wait", req_ready, 0);
            @(negedge clk);
            n++;
        end
        chk("t5_rsp_seen", rsp_valid, 2'b01);
        chk("t5_block_resp", req_ready, 0);
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("t5_block_hs", req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_grant_after", req_ready, 2'b10);
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // reset during WAIT discards the read and restores the pointer
        do_req(0, 1'b0, 32'h0000_0088, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_rsp.delete();
        @(negedge clk);
        chk("t6_ctrl", {busy, config_write, config_read, rsp_valid, req_ready}, 0);
        chk("t6_addr", config_addr_out, 0);
        chk("t6_rdata", rsp_rdata, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;
        contend(3, 0);

        random_mix(8);

        chk("cfg_queue_empty", exp_cfg.size(), 0);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
